// File: rtl/e203_subsys_icb_mstr_pkg.sv
// rtl/e203_subsys_icb_mstr_pkg.sv - shared ICB widths and FSM encodings for the ICB initiator
package e203_subsys_icb_mstr_pkg;

  localparam int ICB_AW = 32;
  localparam int ICB_DW = 32;

  typedef logic [2:0] state_t;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CMD   = 3'd1;
  localparam logic [2:0] ST_RSP   = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;
  localparam logic [2:0] ST_DRAIN = 3'd4;

endpackage

// File: rtl/e203_subsys_icb_mstr_if.sv
// rtl/e203_subsys_icb_mstr_if.sv - ICB command/response channel bundle
interface e203_subsys_icb_mstr_if
  import e203_subsys_icb_mstr_pkg::*;
#(
  parameter int AW = ICB_AW,
  parameter int DW = ICB_DW
) ();

  logic            icb_cmd_valid;
  logic            icb_cmd_ready;
  logic [AW-1:0]   icb_cmd_addr;
  logic            icb_cmd_read;
  logic [DW-1:0]   icb_cmd_wdata;
  logic [DW/8-1:0] icb_cmd_wmask;
  logic            icb_rsp_valid;
  logic            icb_rsp_ready;
  logic            icb_rsp_err;
  logic [DW-1:0]   icb_rsp_rdata;

  modport master (
    output icb_cmd_valid, icb_cmd_addr, icb_cmd_read, icb_cmd_wdata, icb_cmd_wmask,
    output icb_rsp_ready,
    input  icb_cmd_ready, icb_rsp_valid, icb_rsp_err, icb_rsp_rdata
  );

  modport slave (
    input  icb_cmd_valid, icb_cmd_addr, icb_cmd_read, icb_cmd_wdata, icb_cmd_wmask,
    input  icb_rsp_ready,
    output icb_cmd_ready, icb_rsp_valid, icb_rsp_err, icb_rsp_rdata
  );

endinterface

// File: rtl/e203_subsys_icb_mstr_dfflr.sv
// rtl/e203_subsys_icb_mstr_dfflr.sv - load-enable register cleared by async reset
module e203_subsys_icb_mstr_dfflr
  import e203_subsys_icb_mstr_pkg::*;
#(
  parameter int W = ICB_DW
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         lden,
  input  logic [W-1:0] dnxt,
  output logic [W-1:0] qout
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      qout <= '0;
    end else if (lden) begin
      qout <= dnxt;
    end
  end

endmodule

// File: rtl/e203_subsys_icb_mstr.sv
// rtl/e203_subsys_icb_mstr.sv - single-outstanding ICB initiator with response timeout
module e203_subsys_icb_mstr
  import e203_subsys_icb_mstr_pkg::*;
#(
  parameter int AW      = ICB_AW,
  parameter int DW      = ICB_DW,
  parameter int TMO_CYC = 1023,
  parameter int TMO_W   = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [AW-1:0]   req_addr,
  input  logic            req_read,
  input  logic [DW-1:0]   req_wdata,
  input  logic [DW/8-1:0] req_wmask,
  output logic            done_valid,
  input  logic            done_ready,
  output logic [DW-1:0]   done_rdata,
  output logic            done_err,
  output logic            done_tmo,
  e203_subsys_icb_mstr_if.master icb
);

  localparam int MW    = DW / 8;
  localparam int CMD_W = AW + 1 + DW + MW;
  localparam int DON_W = DW + 2;
  localparam bit TMO_EN = (TMO_CYC != 0);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

  state_t           state;
  state_t           state_nxt;
  logic [TMO_W-1:0] tmo_cnt;
  logic             owed;

  logic st_idle, st_cmd, st_rsp, st_done, st_drain;
  assign st_idle  = (state == ST_IDLE);
  assign st_cmd   = (state == ST_CMD);
  assign st_rsp   = (state == ST_RSP);
  assign st_done  = (state == ST_DONE);
  assign st_drain = (state == ST_DRAIN);

  logic req_hsk, cmd_hsk, tmo_fire, done_ld;
  assign req_hsk  = st_idle & req_valid;
  assign cmd_hsk  = st_cmd & icb.icb_cmd_ready;
  // A response arriving on the timeout cycle takes priority over the timeout.
  assign tmo_fire = TMO_EN & st_rsp & ~icb.icb_rsp_valid & (tmo_cnt == TMO_LAST);
  assign done_ld  = st_rsp & (icb.icb_rsp_valid | tmo_fire);

  logic [CMD_W-1:0] cmd_q;
  logic             cmd_read;

  e203_subsys_icb_mstr_dfflr #(.W(CMD_W)) u_cmd_reg (
    .clk  (clk),
    .rst  (rst),
    .lden (req_hsk),
    .dnxt ({req_addr, req_read, req_wdata, req_wmask}),
    .qout (cmd_q)
  );

  assign icb.icb_cmd_addr  = cmd_q[CMD_W-1 -: AW];
  assign cmd_read          = cmd_q[DW+MW];
  assign icb.icb_cmd_read  = cmd_read;
  assign icb.icb_cmd_wdata = cmd_q[MW +: DW];
  assign icb.icb_cmd_wmask = cmd_q[MW-1:0];

  logic [DW-1:0]    rdata_nxt;
  logic [DON_W-1:0] done_q;

  // Writes and timeouts report zero data so the agent never sees stale bus values.
  assign rdata_nxt = (icb.icb_rsp_valid & cmd_read) ? icb.icb_rsp_rdata : '0;

  e203_subsys_icb_mstr_dfflr #(.W(DON_W)) u_done_reg (
    .clk  (clk),
    .rst  (rst),
    .lden (done_ld),
    .dnxt ({rdata_nxt,
            (icb.icb_rsp_valid ? icb.icb_rsp_err : 1'b1),
            ~icb.icb_rsp_valid}),
    .qout (done_q)
  );

  assign done_rdata = done_q[DON_W-1 -: DW];
  assign done_err   = done_q[1];
  assign done_tmo   = done_q[0];

  assign req_ready         = st_idle;
  assign done_valid        = st_done;
  assign icb.icb_cmd_valid = st_cmd;
  assign icb.icb_rsp_ready = st_rsp | st_drain;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (req_valid)             state_nxt = ST_CMD;
      ST_CMD:   if (icb.icb_cmd_ready)     state_nxt = ST_RSP;
      ST_RSP:   if (done_ld)               state_nxt = ST_DONE;
      ST_DONE:  if (done_ready)            state_nxt = owed ? ST_DRAIN : ST_IDLE;
      ST_DRAIN: if (icb.icb_rsp_valid)     state_nxt = ST_IDLE;
      default:                             state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      tmo_cnt <= '0;
      owed    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (cmd_hsk) begin
        tmo_cnt <= '0;
      end else if (st_rsp) begin
        tmo_cnt <= tmo_cnt + TMO_W'(1);
      end
      // The timed-out response is still in flight; it must be swallowed before reuse.
      if (tmo_fire) begin
        owed <= 1'b1;
      end else if (st_drain & icb.icb_rsp_valid) begin
        owed <= 1'b0;
      end
    end
  end

endmodule

// File: doc/e203_subsys_icb_mstr.md
Name: e203_subsys_icb_mstr

Overview:
- Single-outstanding ICB initiator. Converts a simple request/done handshake from a local agent (boot or debug sequencer, power-management controller) into ICB command/response transactions.
- Sits in the subsystem next to the peripheral ICB targets (CLINT, PLIC, AON) and drives one target port through the existing ICB fabric.
- Adds a response timeout so that a dead target cannot hang the requesting agent.

Parameters:
- AW, 32, ICB address width (matches E203_ADDR_SIZE)
- DW, 32, ICB data width (matches E203_XLEN); wmask width is DW/8
- TMO_CYC, 1023, cycles allowed in RSP state before a timeout; 0 disables the timeout
- TMO_W, 10, width of the timeout counter; must satisfy TMO_CYC < 2^TMO_W

Ports:
- clk  in  1  single clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  agent request valid
- req_ready  out  1  agent request accepted
- req_addr  in  AW  target address
- req_read  in  1  1=read, 0=write
- req_wdata  in  DW  write data
- req_wmask  in  DW/8  byte write mask
- done_valid  out  1  transaction result valid
- done_ready  in  1  agent accepts result
- done_rdata  out  DW  read data (0 for writes and on timeout)
- done_err  out  1  bus error or timeout
- done_tmo  out  1  error was a timeout
- icb_cmd_valid  out  1  ICB command valid
- icb_cmd_ready  in  1  ICB command ready
- icb_cmd_addr  out  AW  ICB command address
- icb_cmd_read  out  1  ICB command read
- icb_cmd_wdata  out  DW  ICB command write data
- icb_cmd_wmask  out  DW/8  ICB command write mask
- icb_rsp_valid  in  1  ICB response valid
- icb_rsp_ready  out  1  ICB response ready
- icb_rsp_err  in  1  ICB response error
- icb_rsp_rdata  in  DW  ICB response read data

Behaviour:
- Reset: async on rst rising edge. State=IDLE. Outputs: icb_cmd_valid=0, icb_rsp_ready=0, done_valid=0, done_err=0, done_tmo=0, done_rdata=0. Command registers=0. Timeout counter=0.
- FSM states: IDLE, CMD, RSP, DONE, DRAIN.
- IDLE:
  - req_ready=1.
  - On req_valid, latch addr/read/wdata/wmask and go to CMD.
  - req_ready is 0 in every other state.
- CMD:
  - icb_cmd_valid=1, driven from registers only; no combinational path from req_* to icb_cmd_*.
  - valid and payload are held stable until icb_cmd_ready. No timeout applies in CMD (ICB forbids withdrawing valid).
  - On icb_cmd_ready, go to RSP and clear the counter.
  - First command beat appears on the cycle after request acceptance: one-cycle latency.
- RSP:
  - icb_rsp_ready=1. The counter increments each cycle.
  - On icb_rsp_valid: capture rdata (forced to 0 if write) and err into the done registers, done_tmo=0, go to DONE.
  - If TMO_CYC!=0 and the counter reaches TMO_CYC-1 with no rsp_valid: done_err=1, done_tmo=1, done_rdata=0, go to DONE. The timed-out response is still owed.
  - If rsp_valid and the timeout fire in the same cycle, the response wins: no timeout.
- DONE:
  - done_valid=1, with registered outputs held stable until done_ready.
  - On done_ready: if the timed-out response is still owed, go to DRAIN; else go to IDLE.
  - The next request is accepted no earlier than the cycle after done handshake.
- DRAIN:
  - icb_rsp_ready=1. Wait for icb_rsp_valid, discard its data/err, go to IDLE.
  - This prevents a late response from being matched to a new command.
  - No timeout in DRAIN.
- Owed-response flag: set at timeout, cleared when the late rsp is consumed. A late rsp_valid arriving while in DONE is not accepted (rsp_ready=0 in DONE); it is held by the target until DRAIN.
- icb_rsp_ready is 0 in IDLE, CMD and DONE.
- Minimum transaction: req accept → cmd (1 cycle if ready) → rsp the same cycle as entering RSP → done valid the next cycle. That is 3 cycles from req accept to done_valid with a zero-latency target.
- Reset mid-transaction: all state is dropped immediately. The fabric is reset by the same rst, so no drain is required after reset.

Decomposition:
- Shared package (e203 defines): FSM state encodings (3-bit), ICB field widths.
- Optional sub-module: sirv_gnrl_dfflr-style enable flops for the command and done registers. No other sub-module; the FSM and counter live in one file.

Test Plan:
- Write, zero-wait target: req addr=0x0200_4000 wdata=0x0000_0064 wmask=0xF read=0 → icb_cmd same payload on cycle+1; done_valid on cycle+3 with err=0, rdata=0.
- Read with cmd backpressure 4 cycles and rsp delay 5 cycles: target returns 0xDEAD_BEEF → cmd payload stable while cmd_ready=0; done_rdata=0xDEAD_BEEF, err=0.
- Bus error: target answers rsp_err=1 rdata=0x1234 → done_err=1, done_tmo=0, done_rdata=0x1234.
- Timeout with TMO_CYC=8: target never responds → done_valid after 8 RSP cycles, err=1, tmo=1. A request presented during DONE is not accepted. After done_ready, rsp arrives 20 cycles later: the FSM stays in DRAIN with req_ready=0 until then, discards the rsp, and the next read returns the correct new data.
- Simultaneous: rsp_valid on exactly the timeout cycle with rdata=0x55 → done_tmo=0, done_rdata=0x55, no DRAIN.
- Reset asserted while in RSP with cmd outstanding → all outputs 0 asynchronously. After release, the next request is accepted in IDLE.
